memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
Shares the single memory bus (addr/wdata/rdata/write/size/prot/trans/data_valid/abort) between the instruction-fetch port and the execute-stage data port. It arbitrates requests and issues one registered bus transfer at a time. It waits for data_valid or abort, with a timeout, then returns a one-cycle ack with read data or an abort flag to the owning requester. Data accesses have priority, and a streak limit keeps fetch from starving.

Parameters:
MAX_D_STREAK, 4, consecutive data grants allowed while f_req is pending before fetch is forced.
TIMEOUT_CYCLES, 16, BUSY cycles without data_valid/abort before the transfer is ended with abort.

Ports:
clk  in  1  clock, all state on posedge.
n_reset  in  1  asynchronous active-low reset.
f_req  in  1  fetch request; held with f_addr until f_ack.
f_addr  in  32  fetch word address.
f_ack  out  1  one-cycle completion pulse to fetch.
f_rdata  out  32  fetch read data, valid while f_ack=1.
f_abort  out  1  qualifies f_ack: transfer aborted or timed out.
d_req  in  1  data request; held with d_addr/d_write/d_wdata until d_ack.
d_write  in  1  1=write, 0=read.
d_addr  in  32  data word address.
d_wdata  in  32  write data.
d_ack  out  1  one-cycle completion pulse to data port.
d_rdata  out  32  data read result, valid while d_ack=1.
d_abort  out  1  qualifies d_ack.
priv  in  1  current mode privileged; drives prot[1].
addr  out  32  bus address.
wdata  out  32  bus write data.
write  out  1  bus direction.
size  out  1  always 1 (word).
prot  out  2  {priv, data_access}; data_access=0 for fetch, 1 for data.
trans  out  2  00 idle, 10 nonsequential, 11 sequential.
rdata  in  32  bus read data.
data_valid  in  1  bus completion.
abort  in  1  bus error.

Behaviour:
- Reset (asynchronous, n_reset=0): state IDLE; trans=00, write=0, addr=0, wdata=0, prot=00, size=1; all acks, aborts and rdata outputs 0; streak=0, timer=0, last-owner/last-addr cleared. Reset mid-transfer abandons it: no ack, and a later data_valid is ignored.
- All outputs are registered.
- States:
  - IDLE: at posedge, if any request is present, grant one, drive the bus for exactly one cycle, latch the owner, go ISSUE.
  - ISSUE: drive trans=00, clear timer, go BUSY.
  - BUSY: wait for data_valid, abort or timeout, then go IDLE with ack.
- Grant rule in IDLE:
  - d_req and not (f_req and streak==MAX_D_STREAK): grant data; streak increments if f_req=1, else 0.
  - Otherwise, if f_req: grant fetch; streak=0.
- trans encoding: 11 when the granted owner equals the previous owner and addr equals previous addr+4 (32-bit wrap); otherwise 10.
- Memory samples trans in ISSUE and returns data_valid one cycle later.
- Latency for an unloaded read: request sampled at edge E0, ack high after E3. Three bus-occupied cycles per transfer; the next grant is sampled at the edge after the ack edge.
- Completion in BUSY:
  - abort=1: ack with abort=1, rdata=0. Abort wins if data_valid and abort are both high.
  - data_valid=1: ack with abort=0; rdata captured for reads, 0 for writes.
  - timer reaches TIMEOUT_CYCLES-1 with neither: ack with abort=1.
- Only the owner's ack pulses, for exactly one cycle. The non-owner's ack/abort stay 0.
- data_valid/abort arriving in IDLE or ISSUE is ignored.
- Owner dropping its req during ISSUE/BUSY is illegal. The arbiter still completes the transfer and pulses ack.
- A req still high in IDLE after ack is treated as a new request.
- Timer saturates; it is cleared on entry to BUSY.

Test Plan:
- Single fetch: f_req, f_addr=0x100, memory word 0xE3A01005 -> addr=0x100, trans=10, prot=00 one cycle; f_ack=1, f_rdata=0xE3A01005, f_abort=0 three cycles after request sampled; d_ack stays 0.
- Data write then read-back: d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF, then d_write=0 at 0x200 -> write=1, prot=01 on first transfer; second d_ack with d_rdata=0xDEADBEEF.
- Contention with MAX_D_STREAK=4: d_req and f_req held continuously -> grant order D,D,D,D,F,D,D,D,D,F; sequential data addresses 0x200,0x204 give trans=11 on the second.
- Abort: memory asserts abort with data_valid on a d read -> d_ack=1, d_abort=1, d_rdata=0.
- Timeout: memory never responds to fetch at 0x300 -> f_ack=1, f_abort=1 exactly TIMEOUT_CYCLES=16 cycles after BUSY entry; arbiter returns to IDLE and serves the next d_req normally.
- Reset mid-BUSY: n_reset low for one cycle while a fetch is pending -> outputs zero immediately (trans=00); no f_ack from the abandoned transfer; the late data_valid is ignored.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: groups the two requester ports (instruction fetch and
// execute-stage data) with the shared memory bus.
//   master modport : the arbiter side. It takes the requests and the bus response,
//                    and drives the acks and the bus request.
//   slave modport  : the environment side. This is the requesters plus the memory.
// Fetch port : f_req, f_addr -> f_ack, f_rdata, f_abort
// Data port  : d_req, d_write, d_addr, d_wdata -> d_ack, d_rdata, d_abort
// Bus        : addr, wdata, write, size, prot, trans -> rdata, data_valid, abort
// Mode       : priv (drives prot[1])
interface memory_arbiter_if;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_ack;
   logic [31:0] f_rdata;
   logic        f_abort;

   logic        d_req;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_abort;

   logic        priv;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic        write;
   logic        size;
   logic [1:0]  prot;
   logic [1:0]  trans;
   logic [31:0] rdata;
   logic        data_valid;
   logic        abort;

   modport master (
      input  f_req, f_addr, d_req, d_write, d_addr, d_wdata, priv,
             rdata, data_valid, abort,
      output f_ack, f_rdata, f_abort, d_ack, d_rdata, d_abort,
             addr, wdata, write, size, prot, trans
   );

   modport slave (
      output f_req, f_addr, d_req, d_write, d_addr, d_wdata, priv,
             rdata, data_valid, abort,
      input  f_ack, f_rdata, f_abort, d_ack, d_rdata, d_abort,
             addr, wdata, write, size, prot, trans
   );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory bus between the fetch port and the data port.
// A granted request is driven onto the bus for one cycle with trans = 10 or 11.
// The next cycle drops trans to 00. The arbiter then waits for data_valid or
// abort, or until the timeout expires. Completion is reported as a one-cycle ack
// to the owner only.
// Data requests win arbitration. However, after MAX_D_STREAK consecutive data
// grants with fetch waiting, fetch is forced through.
// Ports:
//   clk     : clock, all state updates on posedge
//   n_reset : asynchronous active-low reset
//   mem_if  : memory_arbiter_if.master (requester ports + memory bus)
module memory_arbiter #(
   parameter int MAX_D_STREAK   = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic              clk,
   input logic              n_reset,
   memory_arbiter_if.master mem_if
);
   localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
   localparam int TIMER_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_t;

   state_t              state_reg;
   logic                owner_d_reg;      // 1 = data port owns the transfer
   logic [STREAK_W-1:0] streak_reg;
   logic [TIMER_W-1:0]  timer_reg;
   logic                last_valid_reg;   // a previous grant exists for the sequential check
   logic                last_owner_d_reg;
   logic [31:0]         last_addr_reg;

   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        write_reg;
   logic [1:0]  prot_reg;
   logic [1:0]  trans_reg;
   logic        f_ack_reg;
   logic [31:0] f_rdata_reg;
   logic        f_abort_reg;
   logic        d_ack_reg;
   logic [31:0] d_rdata_reg;
   logic        d_abort_reg;

   logic        force_fetch;
   logic        grant_d;
   logic        grant_f;
   logic [31:0] grant_addr;
   logic        grant_seq;
   logic        timed_out;
   logic        done;
   logic        end_abort;

   assign force_fetch = mem_if.f_req && (streak_reg == STREAK_W'(MAX_D_STREAK));
   assign grant_d     = mem_if.d_req && !force_fetch;
   assign grant_f     = mem_if.f_req && !grant_d;
   assign grant_addr  = grant_d ? mem_if.d_addr : mem_if.f_addr;
   // A transfer is sequential only if the same owner continues at the next word.
   // The +4 wraps at 32 bits.
   assign grant_seq   = last_valid_reg && (last_owner_d_reg == grant_d) &&
                        (grant_addr == last_addr_reg + 32'd4);
   assign timed_out   = (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));
   assign done        = mem_if.abort || mem_if.data_valid || timed_out;
   // An abort beats data_valid. A timeout with neither signal is also an abort.
   assign end_abort   = mem_if.abort || !mem_if.data_valid;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_reg        <= IDLE;
         owner_d_reg      <= 1'b0;
         streak_reg       <= '0;
         timer_reg        <= '0;
         last_valid_reg   <= 1'b0;
         last_owner_d_reg <= 1'b0;
         last_addr_reg    <= 32'd0;
         addr_reg         <= 32'd0;
         wdata_reg        <= 32'd0;
         write_reg        <= 1'b0;
         prot_reg         <= 2'b00;
         trans_reg        <= 2'b00;
         f_ack_reg        <= 1'b0;
         f_rdata_reg      <= 32'd0;
         f_abort_reg      <= 1'b0;
         d_ack_reg        <= 1'b0;
         d_rdata_reg      <= 32'd0;
         d_abort_reg      <= 1'b0;
      end else begin
         // Ack outputs are single-cycle pulses. They are cleared unless set below.
         f_ack_reg   <= 1'b0;
         f_rdata_reg <= 32'd0;
         f_abort_reg <= 1'b0;
         d_ack_reg   <= 1'b0;
         d_rdata_reg <= 32'd0;
         d_abort_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_d || grant_f) begin
                  addr_reg         <= grant_addr;
                  wdata_reg        <= grant_d ? mem_if.d_wdata : 32'd0;
                  write_reg        <= grant_d && mem_if.d_write;
                  prot_reg         <= {mem_if.priv, grant_d};
                  trans_reg        <= grant_seq ? 2'b11 : 2'b10;
                  owner_d_reg      <= grant_d;
                  last_valid_reg   <= 1'b1;
                  last_owner_d_reg <= grant_d;
                  last_addr_reg    <= grant_addr;
                  // The streak counts data grants only while fetch is being held off.
                  if (grant_d && mem_if.f_req)
                     streak_reg <= streak_reg + STREAK_W'(1);
                  else
                     streak_reg <= '0;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               trans_reg <= 2'b00;
               timer_reg <= '0;
               state_reg <= BUSY;
            end
            BUSY: begin
               if (done) begin
                  if (owner_d_reg) begin
                     d_ack_reg   <= 1'b1;
                     d_abort_reg <= end_abort;
                     d_rdata_reg <= (end_abort || write_reg) ? 32'd0 : mem_if.rdata;
                  end else begin
                     f_ack_reg   <= 1'b1;
                     f_abort_reg <= end_abort;
                     f_rdata_reg <= end_abort ? 32'd0 : mem_if.rdata;
                  end
                  state_reg <= IDLE;
               end else if (timer_reg != '1) begin
                  timer_reg <= timer_reg + TIMER_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign mem_if.addr    = addr_reg;
   assign mem_if.wdata   = wdata_reg;
   assign mem_if.write   = write_reg;
   assign mem_if.size    = 1'b1;
   assign mem_if.prot    = prot_reg;
   assign mem_if.trans   = trans_reg;
   assign mem_if.f_ack   = f_ack_reg;
   assign mem_if.f_rdata = f_rdata_reg;
   assign mem_if.f_abort = f_abort_reg;
   assign mem_if.d_ack   = d_ack_reg;
   assign mem_if.d_rdata = d_rdata_reg;
   assign mem_if.d_abort = d_abort_reg;
endmodule
